// File: rtl/console_pkg.sv
// console_pkg: timing constants, pixel type and fetch-FSM encoding shared by
// the console video path (sync generator, scanline fetch, scan-out).
package console_pkg;

   // Active area and last row of the sync generator's default timing.
   localparam int XRES  = 640;
   localparam int YRES  = 480;
   localparam int YLAST = 520;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } fetch_state_t;

   // Shown for pixels the fetch never delivered (optional scan-out mode).
   localparam rgb888_t UNDERRUN_COLOR = '{r: 8'hFF, g: 8'h00, b: 8'hFF};

   // Row that follows `row`, wrapping to 0 after the generator's last row.
   function automatic logic [11:0] next_row(input logic [11:0] row,
                                            input logic [11:0] last);
      return (row >= last) ? 12'd0 : row + 12'd1;
   endfunction

endpackage

// File: rtl/scanline_bank2.sv
// scanline_bank2: ping-pong line buffer, two DEPTH x 24 simple dual-port RAMs.
// One write port and one registered read port, each with its own bank select.
module scanline_bank2
   import console_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int AW    = 10
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic          i_wbank,
   input  logic [AW-1:0] i_waddr,
   input  rgb888_t       i_wdata,
   input  logic          i_rbank,
   input  logic [AW-1:0] i_raddr,
   output rgb888_t       o_rdata
);

   rgb888_t r_mem0 [DEPTH];
   rgb888_t r_mem1 [DEPTH];
   rgb888_t r_rdata;

   // Write port: one word per cycle into the selected bank.
   // NOTE: state updates use <= so every register samples pre-edge values.
   // NOTE: RAM arrays get no reset; every word is written before it is shown.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         if (i_wbank) r_mem1[i_waddr] <= i_wdata;
         else         r_mem0[i_waddr] <= i_wdata;
      end
   end

   // Read port: registered output, one cycle of latency.
   always_ff @(posedge i_clk) begin
      r_rdata <= i_rbank ? r_mem1[i_raddr] : r_mem0[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/scanline_fetch.sv
// scanline_fetch: prefetches framebuffer line N+1 during the blank of line N
// into a ping-pong buffer and streams RGB with hs/vs delayed by two cycles.
// Optional build macro: SCANOUT_UNDERRUN_FILL_EN (paint unfetched pixels
// magenta instead of showing stale buffer contents).
module scanline_fetch #(
   parameter int XRES    = console_pkg::XRES,
   parameter int YRES    = console_pkg::YRES,
   parameter int YLAST   = console_pkg::YLAST,
   parameter int FB_BASE = 0,
   parameter int ADDR_W  = 30
) (
   input  logic              fbclk,
   input  logic              rst_b,
   input  logic [11:0]       x,
   input  logic [11:0]       y,
   input  logic              hs_in,
   input  logic              vs_in,
   input  logic              border_in,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ack,
   input  logic [23:0]       rd_data,
   output logic              hs,
   output logic              vs,
   output logic [7:0]        r,
   output logic [7:0]        g,
   output logic [7:0]        b,
   output logic              underrun
);

   import console_pkg::*;

   localparam int                AW        = (XRES > 1) ? $clog2(XRES) : 1;
   localparam logic [11:0]       L_XRES    = 12'(XRES);
   localparam logic [11:0]       L_YRES    = 12'(YRES);
   localparam logic [11:0]       L_YLAST   = 12'(YLAST);
   localparam logic [10:0]       L_XRES11  = 11'(XRES);
   localparam logic [10:0]       L_IDX_END = 11'(XRES - 1);
   localparam logic [ADDR_W-1:0] L_FB_BASE = ADDR_W'(FB_BASE);
   localparam logic [ADDR_W-1:0] L_STRIDE  = ADDR_W'(XRES);

   // Fetch control state
   fetch_state_t      r_state;
   logic              r_rd_req;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W-1:0] r_base;
   logic [10:0]       r_idx;
   logic              r_tbank;
   logic [10:0]       r_fill [2];
   logic              r_underrun;

   fetch_state_t      w_state_nxt;
   logic              w_req_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [ADDR_W-1:0] w_base_nxt;
   logic [10:0]       w_idx_nxt;
   logic              w_tbank_nxt;
   logic [10:0]       w_fill_nxt [2];
   logic              w_ur_nxt;
   logic              w_we;

   logic [11:0]       w_next_y;
   logic              w_trigger;
   logic              w_ram_we;
   logic [AW-1:0]     w_raddr;
   rgb888_t           w_ram_rdata;

   // Output pipeline
   logic              r_s1_hs;
   logic              r_s1_vs;
   logic              r_s1_border;
   logic              r_hs;
   logic              r_vs;
   rgb888_t           r_rgb;
   rgb888_t           w_pix;
`ifdef SCANOUT_UNDERRUN_FILL_EN
   logic              r_s1_unfilled;
   logic              w_unfilled;
`endif

   assign w_next_y  = next_row(y, L_YLAST);
   assign w_trigger = (x == L_XRES) && (w_next_y < L_YRES);

   // Next-state and datapath updates for the fetch FSM.
   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_req_nxt     = r_rd_req;
      w_addr_nxt    = r_rd_addr;
      w_base_nxt    = r_base;
      w_idx_nxt     = r_idx;
      w_tbank_nxt   = r_tbank;
      w_fill_nxt[0] = r_fill[0];
      w_fill_nxt[1] = r_fill[1];
      w_ur_nxt      = r_underrun;
      w_we          = 1'b0;

      unique case (r_state)
         IDLE: begin
         end
         FETCH: begin
            if (rd_ack) begin
               w_we                = 1'b1;
               w_idx_nxt           = r_idx + 11'd1;
               w_addr_nxt          = r_rd_addr + 1'b1;
               w_fill_nxt[r_tbank] = r_idx + 11'd1;
               if (r_idx == L_IDX_END) begin
                  w_req_nxt   = 1'b0;
                  w_state_nxt = IDLE;
               end
            end
         end
      endcase

      // A trigger always (re)starts a fetch; landing mid-fetch is an overrun.
      if (w_trigger) begin
         if (r_state == FETCH) w_ur_nxt = 1'b1;
         w_base_nxt              = (w_next_y == 12'd0) ? L_FB_BASE : r_base + L_STRIDE;
         w_tbank_nxt             = w_next_y[0];
         w_idx_nxt               = '0;
         w_addr_nxt              = w_base_nxt;
         w_req_nxt               = 1'b1;
         w_state_nxt             = FETCH;
         w_fill_nxt[w_next_y[0]] = '0;
      end

      // Line about to be shown is not fully in its bank.
      if ((x == 12'd0) && (y < L_YRES) && (r_fill[y[0]] < L_XRES11)) w_ur_nxt = 1'b1;
   end

   // Fetch FSM state register with synchronous reset.
   always_ff @(posedge fbclk) begin
      if (!rst_b) begin
         r_state    <= IDLE;
         r_rd_req   <= 1'b0;
         r_rd_addr  <= L_FB_BASE;
         r_base     <= L_FB_BASE;
         r_idx      <= '0;
         r_tbank    <= 1'b0;
         r_fill[0]  <= '0;
         r_fill[1]  <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_req   <= w_req_nxt;
         r_rd_addr  <= w_addr_nxt;
         r_base     <= w_base_nxt;
         r_idx      <= w_idx_nxt;
         r_tbank    <= w_tbank_nxt;
         r_fill[0]  <= w_fill_nxt[0];
         r_fill[1]  <= w_fill_nxt[1];
         r_underrun <= w_ur_nxt;
      end
   end

   // An ack arriving in a reset cycle belongs to an abandoned fetch.
   assign w_ram_we = w_we & rst_b;

   // Columns past the active width never reach the RAM; border masks them.
   assign w_raddr = (x < L_XRES) ? x[AW-1:0] : '0;

   scanline_bank2 #(
      .DEPTH (XRES),
      .AW    (AW)
   ) u_bank2 (
      .i_clk   (fbclk),
      .i_we    (w_ram_we),
      .i_wbank (r_tbank),
      .i_waddr (r_idx[AW-1:0]),
      .i_wdata (rgb888_t'(rd_data)),
      .i_rbank (y[0]),
      .i_raddr (w_raddr),
      .o_rdata (w_ram_rdata)
   );

`ifdef SCANOUT_UNDERRUN_FILL_EN
   assign w_unfilled = (x >= {1'b0, r_fill[y[0]]});
`endif

   // Stage-2 pixel select: border forces black, optionally flag unfetched words.
   always_comb begin
      w_pix = w_ram_rdata;
`ifdef SCANOUT_UNDERRUN_FILL_EN
      if (r_s1_unfilled) w_pix = UNDERRUN_COLOR;
`endif
      if (r_s1_border) w_pix = '0;
   end

   // Two-stage output pipeline aligning sync strobes with RAM read latency.
   always_ff @(posedge fbclk) begin
      if (!rst_b) begin
         r_s1_hs       <= 1'b0;
         r_s1_vs       <= 1'b0;
         r_s1_border   <= 1'b1;
`ifdef SCANOUT_UNDERRUN_FILL_EN
         r_s1_unfilled <= 1'b0;
`endif
         r_hs          <= 1'b0;
         r_vs          <= 1'b0;
         r_rgb         <= '0;
      end else begin
         r_s1_hs       <= hs_in;
         r_s1_vs       <= vs_in;
         r_s1_border   <= border_in;
`ifdef SCANOUT_UNDERRUN_FILL_EN
         r_s1_unfilled <= w_unfilled;
`endif
         r_hs          <= r_s1_hs;
         r_vs          <= r_s1_vs;
         r_rgb         <= w_pix;
      end
   end

   assign rd_req   = r_rd_req;
   assign rd_addr  = r_rd_addr;
   assign underrun = r_underrun;
   assign hs       = r_hs;
   assign vs       = r_vs;
   assign r        = r_rgb.r;
   assign g        = r_rgb.g;
   assign b        = r_rgb.b;

endmodule

// File: tb/tb_scanline_fetch.sv
// tb_scanline_fetch: acts as sync generator and memory for scanline_fetch.
// Pixel/sync outputs go through a 2-deep scoreboard; fetch-side behaviour is
// checked against a table of (line, column) probes.
`timescale 1ns/1ps
module tb_scanline_fetch;

   localparam int XRES    = 640;
   localparam int YRES    = 480;
   localparam int YLAST   = 520;
   localparam int FB_BASE = 0;
   localparam int ADDR_W  = 30;
   localparam int HTOT    = 1500;
   localparam int HOLD_LN = 46;
`ifdef SCANOUT_UNDERRUN_FILL_EN
   localparam logic [23:0] PIX_639_SLOW = 24'hFF00FF;
`else
   localparam logic [23:0] PIX_639_SLOW = 24'(FB_BASE + 639);
`endif

   logic              fbclk = 1'b0;
   logic              rst_b;
   logic [11:0]       x, y;
   logic              hs_in, vs_in, border_in;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic [23:0]       rd_data;
   logic              hs, vs;
   logic [7:0]        r, g, b;
   logic              underrun;

   scanline_fetch #(
      .XRES(XRES), .YRES(YRES), .YLAST(YLAST), .FB_BASE(FB_BASE), .ADDR_W(ADDR_W)
   ) dut (
      .fbclk(fbclk), .rst_b(rst_b), .x(x), .y(y),
      .hs_in(hs_in), .vs_in(vs_in), .border_in(border_in),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .hs(hs), .vs(vs), .r(r), .g(g), .b(b), .underrun(underrun)
   );

   always #5 fbclk = ~fbclk;

   // Memory model: 0 never acks, 1 acks every cycle, 2 acks every third cycle.
   int          ack_mode = 0;
   int unsigned cyc = 0;
   always @(posedge fbclk) cyc <= cyc + 1;
   assign rd_ack  = rd_req && ((ack_mode == 1) || ((ack_mode == 2) && (cyc % 3 == 0)));
   assign rd_data = rd_addr[23:0];

   typedef struct {
      logic        chk_rgb;
      logic        hs;
      logic        vs;
      logic [23:0] rgb;
   } exp_t;

   typedef enum int { P_REQ, P_ADDR, P_UR } pkind_t;
   typedef struct {
      int     ln;
      int     xv;
      pkind_t kind;
      int     val;
   } probe_t;

   exp_t   sb_q[$];
   probe_t probes[$];
   int     total = 0;
   int     bad   = 0;
   int     ln    = 0;
   int     acks  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_probe(input int l, input int xv, input pkind_t k, input int v);
      probe_t p;
      p.ln = l; p.xv = xv; p.kind = k; p.val = v;
      probes.push_back(p);
   endtask

   // One scan line (or part of it). pmode: 1 = line y holds words y*XRES+x,
   // 2 = slow-fetch line, only columns 5 and 639 have a known value.
   task automatic run_line(input int yv, input int xlo, input int xhi,
                           input bit bforce, input int pmode, input int amode);
      exp_t e;
      logic bd;
      acks = 0;
      for (int xv = xlo; xv <= xhi; xv++) begin
         @(posedge fbclk); #1;
         if (sb_q.size() == 2) begin
            e = sb_q.pop_front();
            check($sformatf("hs ln%0d x%0d", ln, xv), 32'(hs), 32'(e.hs));
            check($sformatf("vs ln%0d x%0d", ln, xv), 32'(vs), 32'(e.vs));
            if (e.chk_rgb) check($sformatf("rgb ln%0d x%0d", ln, xv), 32'({r, g, b}), 32'(e.rgb));
         end
         ack_mode  = (ln == HOLD_LN && xv >= 700 && xv < 800) ? 0 : amode;
         bd        = bforce || (xv >= XRES) || (yv >= YRES) || (xv % 97 == 13);
         x         = 12'(xv);
         y         = 12'(yv);
         border_in = bd;
         hs_in     = 1'($urandom_range(0, 1));
         vs_in     = 1'($urandom_range(0, 1));
         e.hs      = hs_in;
         e.vs      = vs_in;
         e.chk_rgb = (pmode == 1) || (pmode == 2 && !bd && (xv == 5 || xv == 639));
         if (bd)               e.rgb = 24'h0;
         else if (pmode == 1)  e.rgb = 24'(FB_BASE + yv * XRES + xv);
         else if (xv == 5)     e.rgb = 24'(FB_BASE + yv * XRES + 5);
         else                  e.rgb = PIX_639_SLOW;
         sb_q.push_back(e);
         #1;
         foreach (probes[i]) begin
            if (probes[i].ln == ln && probes[i].xv == xv) begin
               case (probes[i].kind)
                  P_REQ:  check($sformatf("rd_req ln%0d x%0d", ln, xv), 32'(rd_req), 32'(probes[i].val));
                  P_ADDR: check($sformatf("rd_addr ln%0d x%0d", ln, xv), 32'(rd_addr), 32'(probes[i].val));
                  default: check($sformatf("underrun ln%0d x%0d", ln, xv), 32'(underrun), 32'(probes[i].val));
               endcase
            end
         end
         if (rd_req && rd_ack) acks++;
      end
      ln++;
   endtask

   initial begin
      int req_seen;

      // ln0 y520: line 0 prefetch, back-to-back acks
      add_probe(0, 640, P_REQ, 0);     add_probe(0, 641, P_REQ, 1);
      add_probe(0, 641, P_ADDR, FB_BASE); add_probe(0, 642, P_ADDR, FB_BASE + 1);
      add_probe(0, 1000, P_ADDR, FB_BASE + 359);
      add_probe(0, 1280, P_REQ, 1);    add_probe(0, 1280, P_ADDR, FB_BASE + 639);
      add_probe(0, 1281, P_REQ, 0);
      // ln1..3 y0..2: line base advances by XRES
      add_probe(1, 641, P_ADDR, FB_BASE + 640);  add_probe(1, 1281, P_REQ, 0);
      add_probe(1, 1, P_UR, 0);
      add_probe(2, 641, P_ADDR, FB_BASE + 1280);
      add_probe(3, 641, P_ADDR, FB_BASE + 1920);
      // ln4..44 y479..519: no fetch for rows >= YRES
      add_probe(4, 641, P_REQ, 0);  add_probe(5, 641, P_REQ, 0);  add_probe(44, 641, P_REQ, 0);
      // ln45 y520: frame wrap restarts at FB_BASE
      add_probe(45, 641, P_REQ, 1); add_probe(45, 641, P_ADDR, FB_BASE); add_probe(45, 1281, P_REQ, 0);
      // ln46 y0: ack withheld for x 700..799
      add_probe(46, 641, P_ADDR, FB_BASE + 640);
      add_probe(46, 700, P_ADDR, FB_BASE + 699); add_probe(46, 700, P_REQ, 1);
      add_probe(46, 799, P_ADDR, FB_BASE + 699); add_probe(46, 799, P_REQ, 1);
      add_probe(46, 1380, P_ADDR, FB_BASE + 1279); add_probe(46, 1381, P_REQ, 0);
      // ln47/48: slow memory leaves line 2 short
      add_probe(47, 641, P_ADDR, FB_BASE + 1280); add_probe(47, 1499, P_UR, 0);
      add_probe(48, 0, P_UR, 0);  add_probe(48, 1, P_UR, 1);

      // Reset values
      rst_b = 1'b0; x = '0; y = '0; hs_in = 1'b0; vs_in = 1'b0; border_in = 1'b1;
      repeat (3) @(posedge fbclk);
      #1;
      check("reset rd_req", 32'(rd_req), 32'd0);
      check("reset rd_addr", 32'(rd_addr), 32'(FB_BASE));
      check("reset rgb", 32'({r, g, b}), 32'd0);
      check("reset hs/vs", 32'({hs, vs}), 32'd0);
      check("reset underrun", 32'(underrun), 32'd0);

      // Reset mid-fetch: start a fetch that never gets acked, then reset
      y = 12'(YLAST);
      rst_b = 1'b1;
      for (int xv = 600; xv <= 700; xv++) begin
         @(posedge fbclk); #1;
         x = 12'(xv);
      end
      check("pre-reset rd_req", 32'(rd_req), 32'd1);
      ack_mode = 1; hs_in = 1'b1; vs_in = 1'b1; border_in = 1'b0; rst_b = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge fbclk); #1;
         x = 12'(701 + k);
         if (k == 0) begin
            check("mid-fetch reset rd_req", 32'(rd_req), 32'd0);
            check("mid-fetch reset rd_addr", 32'(rd_addr), 32'(FB_BASE));
         end
      end
      check("mid-fetch reset underrun", 32'(underrun), 32'd0);
      check("mid-fetch reset rgb", 32'({r, g, b}), 32'd0);
      check("mid-fetch reset hs/vs", 32'({hs, vs}), 32'd0);
      rst_b = 1'b1; hs_in = 1'b0; vs_in = 1'b0; border_in = 1'b1;
      req_seen = 0;
      for (int xv = 706; xv < HTOT; xv++) begin
         @(posedge fbclk); #1;
         x = 12'(xv);
         #1;
         if (rd_req) req_seen++;
      end
      check("fetch resumed after reset", 32'(req_seen), 32'd0);

      // Always-ack memory: prefetch line 0 in vblank, then rows 0..2
      run_line(YLAST, 0, HTOT - 1, 1'b0, 1, 1);
      check("acks y520", 32'(acks), 32'd640);
      for (int yv = 0; yv <= 2; yv++) begin
         run_line(yv, 0, HTOT - 1, 1'b0, 1, 1);
         check($sformatf("acks y%0d", yv), 32'(acks), 32'd640);
      end

      // Bottom rows and vertical blank: no fetch issued
      for (int yv = 479; yv <= 519; yv++) begin
         run_line(yv, 600, 700, 1'b1, 1, 1);
         check($sformatf("blank acks y%0d", yv), 32'(acks), 32'd0);
      end

      // Frame wrap, then row 0 with a 100-cycle ack stall mid-fetch
      run_line(YLAST, 0, HTOT - 1, 1'b0, 1, 1);
      check("acks wrap y520", 32'(acks), 32'd640);
      run_line(0, 0, HTOT - 1, 1'b0, 1, 1);
      check("acks stalled y0", 32'(acks), 32'd640);

      // Slow memory: line 2 cannot finish before it is shown
      run_line(1, 0, HTOT - 1, 1'b0, 1, 2);
      check("slow acks short", 32'(acks < 640), 32'd1);
      run_line(2, 0, 700, 1'b0, 2, 2);
      check("underrun sticky", 32'(underrun), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
